// File: rtl/axis_arb_pkg.sv
// Shared definitions for the AXI4-Stream packet arbiter family:
// FSM state encoding and the round-robin index step.
package axis_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } arb_state_e;

    // Next index after idx, wrapping explicitly at count (count need not be a power of 2)
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned count);
        return (idx + 32'd1 >= count) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/axis_fifo_arb_if.sv
// Stream bundle between S_COUNT sources, the arbiter and the shared FIFO write port.
interface axis_fifo_arb_if #(
    parameter int unsigned S_COUNT    = 4,
    parameter int unsigned DATA_WIDTH = 8
);
    localparam int unsigned CL_S_COUNT = $clog2(S_COUNT);

    logic [S_COUNT*DATA_WIDTH-1:0] input_axis_tdata;
    logic [S_COUNT-1:0]            input_axis_tvalid;
    logic [S_COUNT-1:0]            input_axis_tready;
    logic [S_COUNT-1:0]            input_axis_tlast;
    logic [DATA_WIDTH-1:0]         output_axis_tdata;
    logic                          output_axis_tvalid;
    logic                          output_axis_tready;
    logic                          output_axis_tlast;
    logic [CL_S_COUNT-1:0]         output_axis_tid;

    // Sources plus FIFO side, as seen from outside the arbiter
    modport master (
        output input_axis_tdata, input_axis_tvalid, input_axis_tlast, output_axis_tready,
        input  input_axis_tready, output_axis_tdata, output_axis_tvalid, output_axis_tlast,
        input  output_axis_tid
    );

    // The arbiter itself
    modport slave (
        input  input_axis_tdata, input_axis_tvalid, input_axis_tlast, output_axis_tready,
        output input_axis_tready, output_axis_tdata, output_axis_tvalid, output_axis_tlast,
        output output_axis_tid
    );

endinterface

// File: rtl/axis_fifo_arb_rr_select.sv
// Combinational round-robin pick: first set request searching upward from
// last_grant_i+1, wrapping at S_COUNT.
module rr_select
    import axis_arb_pkg::*;
#(
    parameter int unsigned S_COUNT = 4,
    localparam int unsigned CL_S_COUNT = $clog2(S_COUNT)
) (
    input  logic [S_COUNT-1:0]    req_i,
    input  logic [CL_S_COUNT-1:0] last_grant_i,
    output logic                  found_o,
    output logic [CL_S_COUNT-1:0] index_o
);

    always_comb begin
        int unsigned idx_v;
        logic        hit_v;
        hit_v   = 1'b0;
        index_o = '0;
        idx_v   = rr_next(32'(last_grant_i), S_COUNT);
        for (int unsigned k = 0; k < S_COUNT; k++) begin
            if (!hit_v && req_i[CL_S_COUNT'(idx_v)]) begin
                hit_v   = 1'b1;
                index_o = CL_S_COUNT'(idx_v);
            end
            idx_v = rr_next(idx_v, S_COUNT);
        end
        found_o = hit_v;
    end

endmodule

// File: rtl/axis_fifo_arb.sv
// Packet-granular round-robin arbiter in front of a shared AXI4-Stream FIFO.
// Grant is held for a whole packet; each forwarded beat is tagged with its source.
module axis_fifo_arb
    import axis_arb_pkg::*;
#(
    parameter int unsigned S_COUNT    = 4,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    axis_fifo_arb_if.slave  axis,
    output logic            busy
);

    localparam int unsigned CL_S_COUNT = $clog2(S_COUNT);

    arb_state_e              state_q, state_d;
    logic [CL_S_COUNT-1:0]   grant_q, grant_d;
    logic [CL_S_COUNT-1:0]   last_grant_q, last_grant_d;
    logic [DATA_WIDTH-1:0]   tdata_q, tdata_d;
    logic                    tlast_q, tlast_d;
    logic                    tvalid_q, tvalid_d;
    logic [CL_S_COUNT-1:0]   tid_q, tid_d;
    logic                    busy_q;

    logic [S_COUNT-1:0]      tready_c;
    logic                    out_free_c;
    logic                    accept_c;
    logic                    sel_found_c;
    logic [CL_S_COUNT-1:0]   sel_index_c;
    logic [DATA_WIDTH-1:0]   grant_data_c;
    logic                    grant_valid_c;
    logic                    grant_last_c;

    rr_select #(.S_COUNT(S_COUNT)) u_rr_select (
        .req_i        (axis.input_axis_tvalid),
        .last_grant_i (last_grant_q),
        .found_o      (sel_found_c),
        .index_o      (sel_index_c)
    );

    // Output register can take a beat when empty or draining this cycle
    assign out_free_c    = axis.output_axis_tready | ~tvalid_q;
    assign grant_data_c  = axis.input_axis_tdata[32'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
    assign grant_valid_c = axis.input_axis_tvalid[grant_q];
    assign grant_last_c  = axis.input_axis_tlast[grant_q];

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        tdata_d      = tdata_q;
        tlast_d      = tlast_q;
        tvalid_d     = tvalid_q;
        tid_d        = tid_q;
        tready_c     = '0;
        accept_c     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (sel_found_c) begin
                    grant_d      = sel_index_c;
                    last_grant_d = sel_index_c;
                    state_d      = ST_XFER;
                end
            end
            ST_XFER: begin
                tready_c[grant_q] = out_free_c;
                accept_c          = grant_valid_c & out_free_c;
                if (accept_c && grant_last_c) begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        // A stalled output register (valid & ~ready) simply keeps its defaults
        if (accept_c) begin
            tdata_d  = grant_data_c;
            tlast_d  = grant_last_c;
            tid_d    = grant_q;
            tvalid_d = 1'b1;
        end else if (out_free_c) begin
            tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= CL_S_COUNT'(S_COUNT - 1);
            tdata_q      <= '0;
            tlast_q      <= 1'b0;
            tvalid_q     <= 1'b0;
            tid_q        <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            tdata_q      <= tdata_d;
            tlast_q      <= tlast_d;
            tvalid_q     <= tvalid_d;
            tid_q        <= tid_d;
            busy_q       <= (state_d == ST_XFER);
        end
    end

    assign axis.input_axis_tready  = tready_c;
    assign axis.output_axis_tdata  = tdata_q;
    assign axis.output_axis_tlast  = tlast_q;
    assign axis.output_axis_tvalid = tvalid_q;
    assign axis.output_axis_tid    = tid_q;
    assign busy                    = busy_q;

endmodule

// File: tb/tb_axis_fifo_arb.sv
// Scoreboard bench for axis_fifo_arb: queued source models, a round-robin
// reference and an output monitor, plus a 3-source instance for index wrap.
module tb_axis_fifo_arb;

    localparam int S  = 4;
    localparam int DW = 8;

    typedef struct packed { logic [7:0] d; logic l; } beat_t;
    typedef struct packed { logic [1:0] id; logic [7:0] d; logic l; } obeat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy, busy3;
    always #5 clk = ~clk;

    axis_fifo_arb_if #(.S_COUNT(S), .DATA_WIDTH(DW)) bus ();
    axis_fifo_arb_if #(.S_COUNT(3), .DATA_WIDTH(DW)) bus3 ();

    axis_fifo_arb #(.S_COUNT(S), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .axis(bus), .busy(busy));
    axis_fifo_arb #(.S_COUNT(3), .DATA_WIDTH(DW)) dut3 (
        .clk(clk), .rst(rst), .axis(bus3), .busy(busy3));

    beat_t        srcq [S][$];
    obeat_t       exp_q[$];
    logic [S-1:0] acc_q = '0;
    bit           hold_lo = 1'b0;
    bit           rand_rdy = 1'b0;
    int           n_vec = 0;
    int           n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        n_vec++;
        n_bad++;
        $display("FAIL %s: timed out at %0t", nm, $time);
    endtask

    // First requesting index after last, wrapping modulo S
    function automatic int rr_pick(input logic [S-1:0] v, input int last);
        for (int k = 1; k <= S; k++) begin
            int j;
            j = (last + k) % S;
            if (v[2'(j)]) return j;
        end
        return -1;
    endfunction

    task automatic push_pkt(input int src, input int len, input logic [7:0] base);
        for (int b = 0; b < len; b++)
            srcq[src].push_back('{d: base + 8'(b), l: (b == len - 1)});
    endtask

    // Source and sink drivers: act just after the clock edge
    initial begin
        bus.input_axis_tvalid  = '0;
        bus.input_axis_tdata   = '0;
        bus.input_axis_tlast   = '0;
        bus.output_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < S; i++) begin
                if (rst) srcq[i].delete();
                else if (acc_q[i]) void'(srcq[i].pop_front());
                if (srcq[i].size() > 0) begin
                    bus.input_axis_tvalid[i]       = 1'b1;
                    bus.input_axis_tdata[i*8 +: 8] = srcq[i][0].d;
                    bus.input_axis_tlast[i]        = srcq[i][0].l;
                end else begin
                    bus.input_axis_tvalid[i] = 1'b0;
                    bus.input_axis_tlast[i]  = 1'b0;
                end
            end
            bus.output_axis_tready = hold_lo ? 1'b0 :
                                     rand_rdy ? ($urandom_range(3) != 0) : 1'b1;
        end
    end

    // Monitor: scoreboard on the output, round-robin reference on the input side
    initial begin
        int           last_g, exp_g;
        bit           idle_req, acc_last, prev_hold;
        logic [S-1:0] req_v;
        obeat_t       prev_o, e, cur;
        last_g = S - 1; exp_g = -1; idle_req = 0; acc_last = 0; prev_hold = 0;
        req_v = '0; prev_o = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                last_g = S - 1; exp_g = -1; idle_req = 0; acc_last = 0; prev_hold = 0;
                acc_q = '0;
                exp_q.delete();
                continue;
            end
            cur = obeat_t'({bus.output_axis_tid, bus.output_axis_tdata, bus.output_axis_tlast});
            if (prev_hold) begin
                chk("hold_valid", 32'(bus.output_axis_tvalid), 32'd1);
                chk("hold_fields", 32'(cur), 32'(prev_o));
            end
            if (bus.output_axis_tvalid && bus.output_axis_tready) begin
                if (exp_q.size() == 0) begin
                    timeout("out_unexpected_beat");
                end else begin
                    e = exp_q.pop_front();
                    chk("out_beat", 32'(cur), 32'(e));
                end
            end
            prev_hold = bus.output_axis_tvalid && !bus.output_axis_tready;
            prev_o    = cur;

            if (acc_last) begin
                chk("bubble_busy", 32'(busy), 32'd0);
                exp_g    = -1;
                acc_last = 0;
            end else if (idle_req) begin
                exp_g  = rr_pick(req_v, last_g);
                last_g = exp_g;
                chk("grant_busy", 32'(busy), 32'd1);
            end
            idle_req = 0;
            if (exp_g < 0)
                chk("idle_ready", 32'({busy, bus.input_axis_tready}), 32'd0);
            else if (bus.input_axis_tready != '0)
                chk("ready_grant", 32'(bus.input_axis_tready), 32'(1) << exp_g);

            acc_q = bus.input_axis_tvalid & bus.input_axis_tready;
            for (int i = 0; i < S; i++) begin
                if (acc_q[i]) begin
                    exp_q.push_back('{id: 2'(i), d: bus.input_axis_tdata[i*8 +: 8],
                                      l: bus.input_axis_tlast[i]});
                    if (bus.input_axis_tlast[i]) acc_last = 1;
                end
            end
            if (exp_g < 0 && bus.input_axis_tvalid != '0) begin
                idle_req = 1;
                req_v    = bus.input_axis_tvalid;
            end
        end
    end

    task automatic pulse_rst();
        rst = 1'b1;
        @(negedge clk); #2;
        chk("rst_out", 32'({bus.output_axis_tvalid, bus.output_axis_tid,
                            bus.output_axis_tdata, bus.output_axis_tlast}), 32'd0);
        chk("rst_ready_busy", 32'({busy, bus.input_axis_tready}), 32'd0);
        chk("rst3_state", 32'({busy3, bus3.input_axis_tready, bus3.output_axis_tvalid}), 32'd0);
        rst = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); #2;
        pulse_rst();
    endtask

    task automatic wait_drain(input int max);
        int n;
        bit empty;
        n = 0;
        forever begin
            empty = (exp_q.size() == 0) && !bus.output_axis_tvalid && !busy;
            for (int i = 0; i < S; i++) if (srcq[i].size() != 0) empty = 0;
            if (empty || n >= max) break;
            @(negedge clk); #2;
            n++;
        end
        if (!empty) timeout("drain");
    endtask

    task automatic expect_out(input string nm, input logic v, input logic [1:0] id,
                              input logic [7:0] d, input logic l);
        @(negedge clk); #2;
        chk(nm, 32'({bus.output_axis_tvalid, bus.output_axis_tid, bus.output_axis_tdata,
                     bus.output_axis_tlast}), 32'({v, id, d, l}));
    endtask

    initial begin
        logic [2:0] acc3;
        logic [9:0] got3[$];
        logic [9:0] want3[3];
        int         tids[$];
        int         want_t[6];
        int         cnt1, stall_left;
        bit         pushed0, stalled, seen;

        bus3.input_axis_tvalid  = '0;
        bus3.input_axis_tdata   = '0;
        bus3.input_axis_tlast   = '0;
        bus3.output_axis_tready = 1'b1;
        do_reset();

        // Wrap with 3 sources: grant 2 first, then 0 and 2 together must pick 0
        bus3.input_axis_tdata  = {8'h22, 8'h00, 8'h00};
        bus3.input_axis_tlast  = 3'b111;
        bus3.input_axis_tvalid = 3'b100;
        seen = 0;
        for (int c = 0; c < 25 && got3.size() < 3; c++) begin
            @(negedge clk);
            acc3 = bus3.input_axis_tvalid & bus3.input_axis_tready;
            if (bus3.output_axis_tvalid)
                got3.push_back({bus3.output_axis_tid, bus3.output_axis_tdata});
            @(posedge clk); #1;
            bus3.input_axis_tvalid = bus3.input_axis_tvalid & ~acc3;
            if (got3.size() == 1 && !seen) begin
                seen = 1;
                bus3.input_axis_tdata  = {8'h32, 8'h00, 8'h30};
                bus3.input_axis_tvalid = 3'b101;
            end
        end
        want3[0] = {2'd2, 8'h22}; want3[1] = {2'd0, 8'h30}; want3[2] = {2'd2, 8'h32};
        if (got3.size() < 3) timeout("wrap_beats");
        for (int k = 0; k < 3 && k < got3.size(); k++)
            chk($sformatf("wrap_beat%0d", k), 32'(got3[k]), 32'(want3[k]));

        // Single source latency and back-to-back beats
        do_reset();
        push_pkt(2, 3, 8'hA1);
        expect_out("lat_c1", 1'b0, 2'd0, 8'h00, 1'b0);
        @(negedge clk); #2;
        chk("lat_c2", 32'({bus.output_axis_tvalid, bus.input_axis_tready}), 32'b0_0100);
        expect_out("lat_a1", 1'b1, 2'd2, 8'hA1, 1'b0);
        expect_out("lat_a2", 1'b1, 2'd2, 8'hA2, 1'b0);
        expect_out("lat_a3", 1'b1, 2'd2, 8'hA3, 1'b1);
        wait_drain(20);

        // Simultaneous requests after reset: order 0, 1, 3
        do_reset();
        push_pkt(0, 2, 8'h10);
        push_pkt(1, 2, 8'h20);
        push_pkt(3, 2, 8'h30);
        for (int c = 0; c < 40 && tids.size() < 6; c++) begin
            @(negedge clk); #2;
            if (bus.output_axis_tvalid && bus.output_axis_tready)
                tids.push_back(int'(bus.output_axis_tid));
        end
        want_t = '{0, 0, 1, 1, 3, 3};
        if (tids.size() < 6) timeout("order_beats");
        for (int k = 0; k < 6 && k < tids.size(); k++)
            chk($sformatf("order_tid%0d", k), 32'(tids[k]), 32'(want_t[k]));
        wait_drain(40);

        // Packet lock with a 4-cycle output stall in the middle
        do_reset();
        push_pkt(1, 5, 8'h40);
        cnt1 = 0; stall_left = 0; pushed0 = 0; stalled = 0; seen = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk); #2;
            if (bus.input_axis_tready[0]) begin
                chk("lock_release", 32'(cnt1), 32'd5);
                seen = 1;
                break;
            end
            if (bus.input_axis_tvalid[1] && bus.input_axis_tready[1]) cnt1++;
            if (cnt1 == 1 && !pushed0) begin
                push_pkt(0, 2, 8'h50);
                pushed0 = 1;
            end
            if (cnt1 == 2 && !stalled) begin
                hold_lo = 1; stall_left = 4; stalled = 1;
            end else if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) begin
                    chk("stall_ready", 32'(bus.input_axis_tready), 32'd0);
                    hold_lo = 0;
                end
            end
        end
        if (!seen) timeout("lock_release");
        wait_drain(40);

        // Reset in the middle of a source-3 packet, then 0 wins over 3
        do_reset();
        push_pkt(3, 4, 8'h60);
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk); #2;
            seen = bus.output_axis_tvalid && (bus.output_axis_tdata == 8'h60);
        end
        if (!seen) timeout("rst_mid_pkt");
        pulse_rst();
        push_pkt(3, 1, 8'h70);
        push_pkt(0, 1, 8'h71);
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk); #2;
            if (bus.output_axis_tvalid) begin
                seen = 1;
                chk("post_rst_first", 32'({bus.output_axis_tid, bus.output_axis_tdata}),
                    32'({2'd0, 8'h71}));
            end
        end
        if (!seen) timeout("post_rst_first");
        wait_drain(30);

        // Random traffic with random output backpressure
        do_reset();
        rand_rdy = 1;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk); #2;
            for (int i = 0; i < S; i++)
                if (srcq[i].size() == 0 && $urandom_range(3) == 0)
                    push_pkt(i, int'($urandom_range(5, 1)), 8'($urandom));
        end
        rand_rdy = 0;
        wait_drain(500);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
